// File: rtl/conf_tx_scheduler_pkg.sv
// conf_tx_scheduler_pkg: shared states, header defaults, grant ids and frame length helper
package conf_tx_scheduler_pkg;
  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_CONF_LOAD,
    S_CONF_HDR,
    S_CONF_DATA,
    S_BUF_HDR,
    S_BUF_DATA
  } state_t;
  localparam logic [7:0] CONF_HDR_DEF = 8'hC0;
  localparam logic [7:0] BUF_HDR_DEF = 8'hB0;
  localparam logic GRANT_CONF = 1'b0;
  localparam logic GRANT_BUF = 1'b1;
  function automatic logic [15:0] n_bytes(input int data_width, input int tx_width, input int num_regs);
    return 16'(data_width / tx_width * num_regs);
  endfunction
endpackage

// File: rtl/conf_tx_scheduler_arb.sv
// tx_rr_arbiter2: two-way round-robin grant between configuration and buffer frames
//   clk, rst (async, active-low)
//   req_conf, req_buf   : frame-start candidates
//   update, upd_grant   : frame end, records which source just finished
//   grant_conf, grant_buf : one-hot (or zero) grant
module tx_rr_arbiter2
  import conf_tx_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_conf,
  input  logic req_buf,
  input  logic update,
  input  logic upd_grant,
  output logic grant_conf,
  output logic grant_buf
);
  logic last_grant;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_grant <= GRANT_BUF;
    else if (update) last_grant <= upd_grant;
  assign grant_conf = req_conf && (!req_buf || last_grant == GRANT_BUF);
  assign grant_buf = req_buf && !grant_conf;
endmodule

// File: rtl/conf_tx_scheduler.sv
// conf_tx_scheduler: frames configuration readback and buffer dumps onto one host TX channel
//   clk, rst (async, active-low)
//   conf_cmd                      : readback request pulse
//   sr_request/sr_ack/sr_data/sr_empty : configuration shift register control and data
//   buf_data/buf_valid/buf_last/buf_ready : buffer-dump stream
//   tx_data/tx_valid/tx_ready     : host TX channel
//   busy, err                     : not idle / sticky shift-register sequencing error
module conf_tx_scheduler
  import conf_tx_scheduler_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TX_WIDTH = 8,
  parameter logic [TX_WIDTH-1:0] CONF_HDR = TX_WIDTH'(CONF_HDR_DEF),
  parameter logic [TX_WIDTH-1:0] BUF_HDR = TX_WIDTH'(BUF_HDR_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                conf_cmd,
  output logic                sr_request,
  output logic                sr_ack,
  input  logic [TX_WIDTH-1:0] sr_data,
  input  logic                sr_empty,
  input  logic [TX_WIDTH-1:0] buf_data,
  input  logic                buf_valid,
  input  logic                buf_last,
  output logic                buf_ready,
  output logic [TX_WIDTH-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                err
);
  localparam logic [15:0] NB = n_bytes(DATA_WIDTH, TX_WIDTH, NUM_REGS);
  state_t state, state_d;
  logic [15:0] cnt, cnt_d;
  logic conf_pending, chk_empty, last_hs;
  logic grant_conf, grant_buf, arb_upd, arb_grant;
  tx_rr_arbiter2 u_arb (
    .clk(clk),
    .rst(rst),
    .req_conf(conf_pending),
    .req_buf(buf_valid),
    .update(arb_upd),
    .upd_grant(arb_grant),
    .grant_conf(grant_conf),
    .grant_buf(grant_buf)
  );
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    tx_data = '0;
    tx_valid = 1'b0;
    sr_request = 1'b0;
    sr_ack = 1'b0;
    buf_ready = 1'b0;
    arb_upd = 1'b0;
    arb_grant = GRANT_CONF;
    last_hs = 1'b0;
    case (state)
      S_FLUSH: begin
        // held off while reset is asserted so every output reads zero in reset
        sr_ack = rst;
        cnt_d = cnt + 16'd1;
        if (sr_empty || cnt == NB - 16'd1) begin
          state_d = S_IDLE;
          cnt_d = '0;
        end
      end
      S_IDLE: state_d = grant_conf ? S_CONF_LOAD : grant_buf ? S_BUF_HDR : S_IDLE;
      S_CONF_LOAD: begin
        sr_request = 1'b1;
        state_d = S_CONF_HDR;
      end
      S_CONF_HDR: begin
        tx_data = CONF_HDR;
        tx_valid = 1'b1;
        if (tx_ready) begin
          cnt_d = NB - 16'd1;
          state_d = S_CONF_DATA;
        end
      end
      S_CONF_DATA: begin
        tx_data = sr_data;
        tx_valid = 1'b1;
        sr_ack = tx_ready;
        if (tx_ready) begin
          cnt_d = cnt - 16'd1;
          if (cnt == '0) begin
            state_d = S_IDLE;
            arb_upd = 1'b1;
            arb_grant = GRANT_CONF;
            last_hs = 1'b1;
          end
        end
      end
      S_BUF_HDR: begin
        tx_data = BUF_HDR;
        tx_valid = 1'b1;
        state_d = tx_ready ? S_BUF_DATA : S_BUF_HDR;
      end
      S_BUF_DATA: begin
        tx_data = buf_data;
        tx_valid = buf_valid;
        buf_ready = tx_ready;
        if (buf_valid && tx_ready && buf_last) begin
          state_d = S_IDLE;
          arb_upd = 1'b1;
          arb_grant = GRANT_BUF;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_FLUSH;
      cnt <= '0;
      conf_pending <= 1'b0;
      chk_empty <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      conf_pending <= conf_cmd || (conf_pending && state != S_CONF_LOAD);
      chk_empty <= last_hs;
      // empty too early during data, or still holding words after the last one
      if ((state == S_CONF_DATA && sr_empty) || (chk_empty && !sr_empty)) err <= 1'b1;
    end
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_conf_tx_scheduler.sv
// tb_conf_tx_scheduler: scoreboard bench with shift-register and buffer-source models
module tb_conf_tx_scheduler;
  logic clk = 0, rst = 0, conf_cmd = 0, tx_ready = 0;
  logic sr_request, sr_ack, sr_empty, buf_valid, buf_last, buf_ready, tx_valid, busy, err;
  logic [7:0] sr_data, buf_data, tx_data;
  int tests = 0, fails = 0;
  int cyc = 0, hs_n = 0, ack_n = 0, tv_n = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e_w;
  bit sb_en = 1, chk_ack = 0;
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  conf_tx_scheduler dut (
    .clk(clk),
    .rst(rst),
    .conf_cmd(conf_cmd),
    .sr_request(sr_request),
    .sr_ack(sr_ack),
    .sr_data(sr_data),
    .sr_empty(sr_empty),
    .buf_data(buf_data),
    .buf_valid(buf_valid),
    .buf_last(buf_last),
    .buf_ready(buf_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .err(err)
  );
  logic [15:0] regs[8];
  logic [127:0] sr_q = {8{16'hA55A}};
  int sr_cnt = 16, load_cnt = 16;
  assign sr_data = sr_q[7:0];
  assign sr_empty = sr_cnt == 0;
  always @(posedge clk)
    if (sr_request) begin
      for (int r = 0; r < 8; r++) sr_q[r*16 +: 16] <= regs[r];
      sr_cnt <= load_cnt;
    end else if (sr_ack && sr_cnt != 0) begin
      sr_q <= sr_q >> 8;
      sr_cnt <= sr_cnt - 1;
    end
  logic [8:0] bmem[64];
  logic [5:0] bwr = 0, brd = 0;
  assign buf_valid = brd != bwr;
  assign buf_data = bmem[brd][7:0];
  assign buf_last = bmem[brd][8];
  always @(posedge clk) if (buf_valid && buf_ready) brd <= brd + 6'd1;
  always @(negedge clk)
    if (rst) begin
      if (tx_valid) tv_n++;
      if (sr_ack && sr_cnt != 0) ack_n++;
      if (tx_valid && tx_ready) begin
        hs_n++;
        if (sb_en) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_extra: got %h, expected no word", tx_data);
          end else begin
            e_w = exp_q.pop_front();
            if (tx_data !== e_w) begin
              fails++;
              $display("FAIL sb_word: got %h, expected %h", tx_data, e_w);
            end
          end
        end
      end
      if (chk_ack && sr_ack) begin
        tests++;
        if (!(tx_valid && tx_ready)) begin
          fails++;
          $display("FAIL ack_hs: sr_ack=1 with valid=%b ready=%b, expected handshake", tx_valid, tx_ready);
        end
      end
      if (chk_ack && prev_stall) begin
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          fails++;
          $display("FAIL stall_hold: got valid=%b data=%h, expected 1 %h", tx_valid, tx_data, prev_data);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_conf_exp();
    exp_q.push_back(8'hC0);
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 2; b++) exp_q.push_back(8'((regs[r] >> (8 * b)) & 16'h00FF));
  endtask
  task automatic push_buf_exp(input logic [7:0] base, input int n);
    exp_q.push_back(8'hB0);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
  endtask
  task automatic load_buf(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bmem[bwr] = {i == n - 1, base + 8'(i)};
      bwr = bwr + 6'd1;
    end
  endtask
  task automatic pulse_conf();
    conf_cmd = 1;
    tick(1);
    conf_cmd = 0;
  endtask
  task automatic wait_idle(input int max, input string name);
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = !busy && exp_q.size() == 0;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b pending=%0d words, expected idle and 0", name, busy, exp_q.size());
      exp_q.delete();
    end
    tick(1);
  endtask
  task automatic wait_flush(input int max, input string name);
    bit ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b, expected 0", name, busy);
    end
    tick(1);
  endtask
  task automatic test_reset();
    int a0, t0;
    #2;
    tests++;
    if ({tx_valid, sr_request, sr_ack, buf_ready, err, busy} !== 6'b000001 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_vals: got v/req/ack/rdy/err/busy=%b data=%h, expected 000001 00",
               {tx_valid, sr_request, sr_ack, buf_ready, err, busy}, tx_data);
    end
    tick(2);
    a0 = ack_n;
    t0 = tv_n;
    rst = 1;
    wait_flush(60, "flush");
    tests++;
    if (ack_n - a0 != 16) begin
      fails++;
      $display("FAIL flush_acks: got %0d, expected 16", ack_n - a0);
    end
    tests++;
    if (tv_n != t0) begin
      fails++;
      $display("FAIL flush_valid: got %0d valid cycles, expected 0", tv_n - t0);
    end
  endtask
  task automatic test_arbitration();
    int h0 = hs_n;
    tx_ready = 1;
    push_conf_exp();
    push_buf_exp(8'h50, 5);
    push_conf_exp();
    push_buf_exp(8'h60, 5);
    pulse_conf();
    load_buf(8'h50, 5);
    load_buf(8'h60, 5);
    tick(8);
    pulse_conf();
    wait_idle(300, "arb");
    tests++;
    if (hs_n - h0 != 46) begin
      fails++;
      $display("FAIL arb_words: got %0d, expected 46", hs_n - h0);
    end
    tests++;
    if (buf_ready !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL arb_idle: got buf_ready=%b err=%b, expected 0 0", buf_ready, err);
    end
  endtask
  task automatic test_conf_basic();
    int h0 = hs_n, a0 = ack_n, c0, lat = -1;
    tx_ready = 1;
    push_conf_exp();
    c0 = cyc;
    pulse_conf();
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (tx_valid) lat = cyc - c0;
    end
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL conf_latency: got %0d, expected 3", lat);
    end
    wait_idle(100, "conf");
    tests++;
    if (hs_n - h0 != 17 || ack_n - a0 != 16) begin
      fails++;
      $display("FAIL conf_counts: got %0d words %0d acks, expected 17 16", hs_n - h0, ack_n - a0);
    end
    tests++;
    if (err !== 1'b0 || sr_empty !== 1'b1) begin
      fails++;
      $display("FAIL conf_end: got err=%b sr_empty=%b, expected 0 1", err, sr_empty);
    end
  endtask
  task automatic test_stall();
    int a0 = ack_n;
    bit ok = 0;
    chk_ack = 1;
    push_conf_exp();
    pulse_conf();
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = exp_q.size() == 0 && !busy;
      @(posedge clk);
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
    tx_ready = 1;
    chk_ack = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_timeout: pending=%0d words, expected 0", exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (ack_n - a0 != 16 || err !== 1'b0) begin
      fails++;
      $display("FAIL stall_acks: got %0d acks err=%b, expected 16 0", ack_n - a0, err);
    end
    tick(1);
  endtask
  task automatic test_reset_mid();
    int h0 = hs_n, a0, t0;
    tx_ready = 1;
    push_conf_exp();
    pulse_conf();
    for (int i = 0; i < 50 && hs_n - h0 < 8; i++) @(posedge clk);
    #1 rst = 0;
    #1;
    tests++;
    if ({tx_valid, sr_request, sr_ack, buf_ready, err, busy} !== 6'b000001 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL abort_vals: got v/req/ack/rdy/err/busy=%b data=%h, expected 000001 00",
               {tx_valid, sr_request, sr_ack, buf_ready, err, busy}, tx_data);
    end
    exp_q.delete();
    tick(2);
    a0 = ack_n;
    t0 = tv_n;
    rst = 1;
    wait_flush(60, "drain");
    tests++;
    if (ack_n - a0 != 9 || tv_n != t0) begin
      fails++;
      $display("FAIL drain: got %0d acks %0d valid, expected 9 0", ack_n - a0, tv_n - t0);
    end
    h0 = hs_n;
    push_conf_exp();
    pulse_conf();
    wait_idle(100, "clean");
    tests++;
    if (hs_n - h0 != 17 || err !== 1'b0) begin
      fails++;
      $display("FAIL clean_frame: got %0d words err=%b, expected 17 0", hs_n - h0, err);
    end
  endtask
  task automatic test_err();
    int h0 = hs_n;
    bit ok = 0;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_pre: got %b, expected 0", err);
    end
    sb_en = 0;
    load_cnt = 10;
    tx_ready = 1;
    pulse_conf();
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = hs_n - h0 == 17 && !busy;
    end
    tests++;
    if (!ok || err !== 1'b1) begin
      fails++;
      $display("FAIL err_set: got err=%b done=%b, expected 1 1", err, ok);
    end
    tick(5);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %b, expected 1", err);
    end
    rst = 0;
    #1;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got %b, expected 0", err);
    end
    tick(1);
    rst = 1;
    load_cnt = 16;
    sb_en = 1;
    wait_flush(60, "err_flush");
  endtask
  initial begin
    for (int r = 0; r < 8; r++) regs[r] = {8'(2 * r + 1), 8'(2 * r + 2)};
    test_reset();
    test_arbitration();
    test_conf_basic();
    test_stall();
    test_reset_mid();
    test_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/conf_tx_scheduler.md
# conf_tx_scheduler

Schedules the single byte-wide host TX channel between two frame sources: configuration readback, via the configuration shift register, and a buffer-dump byte stream. It sequences the shift register (load request, per-byte acks, empty check) and frames each transfer with a header byte. It also arbitrates frame starts round-robin and never interleaves frames. It sits between the configuration register bank and the host TX interface.

## Interface
- NUM_REGS, 8, number of configuration registers
- DATA_WIDTH, 16, bits per register
- TX_WIDTH, 8, bits per transferred word; DATA_WIDTH must be a multiple
- CONF_HDR, 8'hC0, header word of a configuration frame
- BUF_HDR, 8'hB0, header word of a buffer frame
- clk  in  1  single clock; everything on posedge
- rst  in  1  reset, asynchronous, active-low
- conf_cmd  in  1  one-cycle pulse: request a configuration readback
- sr_request  out  1  load strobe to shift register
- sr_ack  out  1  shift strobe to shift register
- sr_data  in  TX_WIDTH  current lowest word of shift register
- sr_empty  in  1  shift register drained flag
- buf_data  in  TX_WIDTH  buffer-dump word
- buf_valid  in  1  buf_data valid
- buf_last  in  1  buf_data is last word of frame
- buf_ready  out  1  buffer word accepted when buf_valid & buf_ready
- tx_data  out  TX_WIDTH  word to host TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  TX sink accepts when tx_valid & tx_ready
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky shift-register sequencing error

## Operation
- N_BYTES = DATA_WIDTH/TX_WIDTH*NUM_REGS (16 at defaults); byte counter 16 bits.
- States: FLUSH, IDLE, CONF_LOAD, CONF_HDR, CONF_DATA, BUF_HDR, BUF_DATA.
- conf_cmd sets conf_pending in any state. A second pulse while pending or while a configuration frame is in progress sets pending again, with no queue depth beyond 1.
- FLUSH (entered from reset): pulse sr_ack every cycle; tx_valid=0. Exit to IDLE when sr_empty=1 or after N_BYTES acks. This clears a shift register left mid-transfer.
- IDLE arbitration (candidates: conf_pending, buf_valid):
  - If only one candidate is present, it wins.
  - If both are present, the source not granted last wins. last_grant resets to BUF, so configuration wins first.
  - Conf grant goes to CONF_LOAD; buf grant goes to BUF_HDR.
- CONF_LOAD: sr_request=1 for exactly one cycle, clear conf_pending (unless conf_cmd in same cycle), then CONF_HDR.
- CONF_HDR: tx_data=CONF_HDR, tx_valid=1. On handshake, counter=N_BYTES-1 and go to CONF_DATA.
- CONF_DATA:
  - tx_data=sr_data and tx_valid=1.
  - sr_ack = tx_ready, combinational, one pulse per accepted word.
  - On each handshake, decrement the counter. On the handshake at counter=0, go to IDLE with last_grant=CONF.
- BUF_HDR: tx_data=BUF_HDR, tx_valid=1. On handshake go to BUF_DATA.
- BUF_DATA:
  - tx_data=buf_data, tx_valid=buf_valid, buf_ready=tx_ready.
  - On a handshake with buf_last=1, go to IDLE with last_grant=BUF.
- err is set, and stays set until reset, in two cases:
  - sr_empty=1 in CONF_DATA before the final handshake.
  - sr_empty=0 in the cycle after the final configuration handshake.

## Timing
- Reset values: tx_valid=0, tx_data=0, sr_request=0, sr_ack=0, buf_ready=0, err=0, busy=1 (state FLUSH), conf_pending=0.
- Reset asserted mid-frame aborts immediately: no partial-frame completion, and the next frame always starts with a header.
- conf_cmd to first header word valid: 3 cycles (IDLE→CONF_LOAD→CONF_HDR).
- Shift register is loaded at the edge ending CONF_LOAD, so sr_data is valid from the first CONF_DATA cycle.
- Throughput: one word per cycle with tx_ready held high; a configuration frame takes N_BYTES+1 handshakes.
- tx_data/tx_valid remain stable while tx_valid=1 and tx_ready=0. BUF_DATA follows the source instead.
- buf_ready=0 outside BUF_DATA.
- Simultaneous conf_cmd and buf_valid in IDLE: the round-robin rule above applies.
- Back-to-back frames have one IDLE cycle between them.

## Structure
- Shared defines header: state encodings, CONF_HDR/BUF_HDR defaults, N_BYTES expression, GRANT_CONF/GRANT_BUF constants.
- One sub-module, tx_rr_arbiter2: 2-way round-robin grant with a last_grant register, updated on frame end.
- Top-level ties the shift register's reset to the same reset source.

## Test plan
- Reset, then an idle shift register → FLUSH issues 16 sr_ack pulses, then IDLE; busy falls; no tx_valid.
- conf_cmd with registers 0x0102..0x0F10, tx_ready=1 → C0 then 16 words LSB-first, then IDLE; err=0; sr_empty=1 one cycle after the last word.
- Random tx_ready stalls (50%) during a configuration frame → tx_data held stable under stall; exactly 16 sr_ack pulses, all coincident with handshakes.
- conf_cmd and buf_valid in the same cycle, both repeated → frame order CONF, BUF, CONF, BUF; the 5-word buf frame with buf_last on word 5 is framed B0 + 5 words.
- Reset asserted after 7 configuration words → outputs zero immediately; FLUSH drains the remaining words without tx_valid; the next conf_cmd yields a clean 17-word frame.
- Shift-register model raising sr_empty after 10 acks → err=1 and stays 1 until reset.
